// File: rtl/case_conv_arbiter.sv
// Round-robin front end for a shared combinational case-conversion datapath:
// registers the winning byte onto conv_x, waits a settle time, captures conv_y.
//
// state  | meaning
// IDLE   | waiting for a requester; readys driven combinationally
// SETTLE | conv_x held, counting down until conv_y is trusted
// OUT    | converted byte presented downstream until out_ready
module case_conv_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic [7:0]       conv_x,
  input  logic [7:0]       conv_y,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] mod_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

  localparam logic [3:0]       CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] orig;
  logic       last_grant;
  logic       grant0, grant1;
  logic [7:0] sel_data;

  // Requester 0 wins a tie whenever requester 1 was served last, and vice versa.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant))
        grant0 = 1'b1;
      else if (req1_valid && (!req0_valid || !last_grant))
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_data   = grant0 ? req0_data : req1_data;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0)      state_nxt = OUT;
      OUT:     if (out_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      conv_x     <= 8'd0;
      orig       <= 8'd0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      xfer_count <= '0;
      mod_count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            conv_x     <= sel_data;
            orig       <= sel_data;
            out_src    <= grant1;
            last_grant <= grant1;
            cnt        <= CNT_INIT;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            out_data  <= conv_y;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (xfer_count != '1) xfer_count <= xfer_count + CNT_ONE;
            if ((out_data != orig) && (mod_count != '1)) mod_count <= mod_count + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_conv_arbiter.sv
// Bench for case_conv_arbiter: four instances (settle 2, 1, 15, and a 2-bit
// counter variant) each driving a delayed Latin-1 uppercase datapath model.
module tb_case_conv_arbiter;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        r0v [NI];
  logic        r1v [NI];
  logic        ordy[NI];
  logic [7:0]  r0d [NI];
  logic [7:0]  r1d [NI];
  wire         r0r [NI];
  wire         r1r [NI];
  wire         ov  [NI];
  wire         osrc[NI];
  wire         bsy [NI];
  wire  [7:0]  cx  [NI];
  wire  [7:0]  cy  [NI];
  wire  [7:0]  od  [NI];
  wire  [15:0] xc  [NI];
  wire  [15:0] mc  [NI];

  int tests = 0;
  int fails = 0;
  int exp_x[NI];
  int exp_m[NI];

  // ISO-8859-1 lowercase to uppercase: a-z and 0xE0-0xFE except the division sign.
  function automatic logic [7:0] upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    if (c >= 8'hE0 && c <= 8'hFE && c != 8'hF7) return c - 8'h20;
    return c;
  endfunction

  function automatic int settle_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 15;
      default: return 1;
    endcase
  endfunction

  function automatic int cmax(input int k);
    return (k == 3) ? 3 : 65535;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign #3 cy[g] = upper(cx[g]);
    if (g == 3) begin : g_small
      wire [1:0] xs, ms;
      case_conv_arbiter #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[g]), .req0_data(r0d[g]), .req0_ready(r0r[g]),
        .req1_valid(r1v[g]), .req1_data(r1d[g]), .req1_ready(r1r[g]),
        .conv_x(cx[g]), .conv_y(cy[g]),
        .out_valid(ov[g]), .out_data(od[g]), .out_src(osrc[g]), .out_ready(ordy[g]),
        .busy(bsy[g]), .xfer_count(xs), .mod_count(ms));
      assign xc[g] = {14'd0, xs};
      assign mc[g] = {14'd0, ms};
    end else begin : g_full
      case_conv_arbiter #(.SETTLE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15)), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v[g]), .req0_data(r0d[g]), .req0_ready(r0r[g]),
        .req1_valid(r1v[g]), .req1_data(r1d[g]), .req1_ready(r1r[g]),
        .conv_x(cx[g]), .conv_y(cy[g]),
        .out_valid(ov[g]), .out_data(od[g]), .out_src(osrc[g]), .out_ready(ordy[g]),
        .busy(bsy[g]), .xfer_count(xc[g]), .mod_count(mc[g]));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      exp_x[k] = 0;
      exp_m[k] = 0;
    end
  endtask

  // One byte end to end; the other requester waits during any backpressure.
  task automatic send_byte(input int k, input int src, input logic [7:0] b, input int stall);
    int lat;
    int guard;
    logic [7:0] hold;
    @(negedge clk);
    if (src == 0) begin r0v[k] = 1'b1; r0d[k] = b; end
    else          begin r1v[k] = 1'b1; r1d[k] = b; end
    #1;
    guard = 0;
    while (!(src == 0 ? r0r[k] : r1r[k]) && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    chk("accept_ready", {31'd0, (src == 0 ? r0r[k] : r1r[k])}, 1);
    chk("ready_excl", {31'd0, r0r[k] & r1r[k]}, 0);
    @(posedge clk);
    @(negedge clk);
    r0v[k] = 1'b0; r1v[k] = 1'b0;
    r0d[k] = 8'($urandom); r1d[k] = 8'($urandom);
    chk("conv_x", {24'd0, cx[k]}, {24'd0, b});
    chk("busy", {31'd0, bsy[k]}, 1);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk("latency", lat, settle_of(k));
    chk("out_data", {24'd0, od[k]}, {24'd0, upper(b)});
    chk("out_src", {31'd0, osrc[k]}, src);
    hold = od[k];
    for (int i = 0; i < stall; i++) begin
      if (src == 0) r1v[k] = 1'b1; else r0v[k] = 1'b1;
      #1;
      chk("bp_readys", {30'd0, r0r[k], r1r[k]}, 0);
      @(negedge clk);
      chk("bp_valid", {31'd0, ov[k]}, 1);
      chk("bp_data", {24'd0, od[k]}, {24'd0, hold});
      chk("bp_conv_x", {24'd0, cx[k]}, {24'd0, b});
    end
    r0v[k] = 1'b0; r1v[k] = 1'b0;
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    if (exp_x[k] < cmax(k)) exp_x[k]++;
    if (upper(b) != b && exp_m[k] < cmax(k)) exp_m[k]++;
    chk("done_valid", {31'd0, ov[k]}, 0);
    chk("xfer_count", {16'd0, xc[k]}, exp_x[k]);
    chk("mod_count", {16'd0, mc[k]}, exp_m[k]);
  endtask

  logic [7:0] sweep [19] = '{8'd40, 8'd72, 8'd183, 8'd131, 8'd124, 8'd20, 8'd235, 8'd97, 8'd65,
                             8'd122, 8'd71, 8'd109, 8'd146, 8'd48, 8'd207, 8'd58, 8'd123,
                             8'd148, 8'd127};

  initial begin
    int seen;
    int both;
    int n;
    int guard;
    int srcs[4];
    logic [7:0] datas[4];
    for (int k = 0; k < NI; k++) begin
      r0v[k] = 1'b0; r1v[k] = 1'b0; ordy[k] = 1'b0;
      r0d[k] = 8'd0; r1d[k] = 8'd0;
    end
    clear_model();

    #12;
    for (int k = 0; k < NI; k++) begin
      chk("rst_conv_x", {24'd0, cx[k]}, 0);
      chk("rst_out", {22'd0, od[k], ov[k], osrc[k]}, 0);
      chk("rst_busy_ready", {29'd0, bsy[k], r0r[k], r1r[k]}, 0);
      chk("rst_counts", {xc[k], mc[k]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    send_byte(0, 0, 8'd97, 0);
    send_byte(0, 1, 8'd183, 0);
    send_byte(0, 0, 8'd122, 10);

    // Reset while byte 123 is settling.
    @(negedge clk);
    r0v[0] = 1'b1; r0d[0] = 8'd123;
    #1;
    chk("mid_accept", {31'd0, r0r[0]}, 1);
    @(posedge clk);
    #2;
    r0v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_conv_x", {24'd0, cx[0]}, 0);
    chk("mid_rst_state", {28'd0, bsy[0], ov[0], r0r[0], r1r[0]}, 0);
    chk("mid_rst_counts", {xc[0], mc[0]}, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("mid_no_ghost", seen, 0);
    chk("mid_counts_after", {xc[0], mc[0]}, 0);

    // Both requesters valid straight out of reset.
    @(negedge clk);
    rst_n = 1'b0;
    r0v[0] = 1'b1; r0d[0] = 8'd72;
    r1v[0] = 1'b1; r1d[0] = 8'd109;
    ordy[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    both = 0; n = 0; guard = 0;
    while (n < 4 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
      if (r0r[0] && r1r[0]) both++;
      if (ov[0]) begin
        srcs[n] = int'(osrc[0]);
        datas[n] = od[0];
        n++;
      end
    end
    r0v[0] = 1'b0; r1v[0] = 1'b0;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("rr_both_ready", both, 0);
    chk("rr_outputs", n, 4);
    for (int i = 0; i < n; i++) begin
      chk("rr_src", srcs[i], i % 2);
      chk("rr_data", {24'd0, datas[i]}, {24'd0, upper(i % 2 == 1 ? 8'd109 : 8'd72)});
    end
    chk("rr_xfer", {16'd0, xc[0]}, 4);
    chk("rr_mod", {16'd0, mc[0]}, 2);

    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 19; i++)
        send_byte(k, int'($urandom_range(1, 0)), sweep[i], int'($urandom_range(3, 0)));
      chk("sweep_xfer", {16'd0, xc[k]}, 19);
      chk("sweep_mod", {16'd0, mc[k]}, exp_m[k]);
    end

    for (int i = 0; i < 5; i++)
      send_byte(3, i % 2, 8'd97, 0);
    chk("sat_xfer", {16'd0, xc[3]}, 3);
    chk("sat_mod", {16'd0, mc[3]}, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
